// File: rtl/mips5_pkg.sv
// rtl/mips5_pkg.sv - shared fetch-path constants and the buffered {pc, instr} entry type
package mips5_pkg;

    localparam int XLEN = 32;

    // First fetch address after reset unless the instantiating design overrides it.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Encoding of a NOP; also the instruction value held by idle FIFO slots.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - synchronous FIFO of fetch entries with clear and same-cycle push/pop
module prefetch_fifo
    import mips5_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);

    // Next-state for storage and pointers; clear wins over any push or pop.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = push_entry;
                wptr_d        = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers; slots reset to zero so the head reads as 0 while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // The upstream credit scheme must never push into a full FIFO without a pop.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/if_prefetch_buffer.sv
// rtl/if_prefetch_buffer.sv - in-order imem prefetcher with credit-limited issue, FIFO and redirect flush
module if_prefetch_buffer
    import mips5_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    input  logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]  MAXO_W  = CW'(MAX_OUTSTANDING);

    logic [31:0]   next_pc_q, next_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_pop;
    fetch_entry_t  fifo_head, push_entry;
    logic [CW:0]   in_use;
    logic          credit_ok, req_fire, rsp_accept, rsp_drop, rsp_push;
    logic          redirect_pc_unused;

    // Word alignment is forced on redirect, so the low target bits are never consumed.
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Credits use registered counts only: every outstanding request owns a FIFO slot.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok = (in_use < DEPTH_W) && (outstanding_q < MAXO_W);

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = rst ? '0 : next_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are strays (e.g. from before a reset).
    assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop   = rsp_accept && (discard_q != '0);
    assign rsp_push   = rsp_accept && (discard_q == '0);
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign fetch_valid = !fifo_empty;
    assign fetch_pc    = fifo_head.pc;
    assign fetch_instr = fifo_head.instr;
    assign fifo_pop    = fetch_valid && fetch_ready;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (rsp_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .clear      (redirect_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    // PC counters and credit/discard bookkeeping; a redirect reloads both PCs and
    // turns every request still unanswered after this cycle into a pending discard.
    always_comb begin
        next_pc_d     = next_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);
        discard_d     = discard_q - CW'(rsp_drop);
        if (req_fire) begin
            next_pc_d = next_pc_q + 32'd4;
        end
        if (rsp_push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (redirect_valid) begin
            next_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d  = {redirect_pc[31:2], 2'b00};
            discard_d = outstanding_d;
        end
    end

    // Control state registers; reset abandons all in-flight requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc_q     <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            next_pc_q     <= next_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Discards are a subset of outstanding requests, which are bounded by the credit limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (outstanding_q <= MAXO_W);
            assert (discard_q <= outstanding_q);
        end
    end

    // Exactly one of drop/push per accepted response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rsp_drop && rsp_push));
        end
    end

endmodule

// File: doc/if_prefetch_buffer.md
Name: if_prefetch_buffer

Overview:
- Instruction-fetch front end that sits directly upstream of if_stage.
- Issues in-order word requests to a variable-latency instruction memory and buffers the returned {pc, instr} pairs in a small FIFO.
- Presents the FIFO head to the IF stage with a valid/ready handshake.
- On an EX-stage redirect it flushes the buffer, discards in-flight responses and restarts fetching at the redirect target.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, max accepted-but-unanswered imem requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
imem_req_valid  output  1  request valid
imem_req_addr  output  32  word address of request
imem_req_ready  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  response valid (in order, one per accepted request)
imem_rsp_data  input  32  instruction word
fetch_valid  output  1  FIFO head valid
fetch_pc  output  32  PC of head entry
fetch_instr  output  32  instruction of head entry
fetch_ready  input  1  IF stage consumes head (pc_write/ifid_write)
redirect_valid  input  1  EX redirect (branch/jump taken)
redirect_pc  input  32  redirect target

Behaviour:
- Interface: one clock domain, clk; reset rst is asynchronous, active-high.
- Reset, asynchronous:
  - next_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - All outputs 0, including imem_req_addr.
  - Reset mid-operation abandons all in-flight requests. Any later imem_rsp_valid with outstanding==0 and discard==0 is ignored.
- Request issue:
  - imem_req_valid=1 when: not in reset, redirect_valid==0, (occupancy + outstanding) < DEPTH, and outstanding < MAX_OUTSTANDING.
  - Credits are computed from registered counts only; no combinational path from fetch_ready to imem_req_valid.
  - imem_req_addr = next_pc.
  - Handshake fires when valid && ready: next_pc += 4 (wraps 32'hFFFF_FFFC -> 0); outstanding++.
  - addr/valid stay stable while ready==0.
- Response, imem_rsp_valid:
  - If discard>0: drop it and decrement discard.
  - Otherwise push {pc_of_oldest_outstanding, data}.
  - PC tracking: a small tag queue of issued addresses, or rsp_pc counter = address of oldest outstanding; the counter is sufficient because responses are in order.
  - outstanding-- on every response.
- Output: fetch_valid = !empty; fetch_pc/fetch_instr = head entry.
  - A pop occurs when fetch_valid && fetch_ready.
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot).
- Latency: request accepted in cycle t, response in t+k (k>=1), fetch_valid in t+k+1. No bypass from response to output.
- Redirect, redirect_valid=1 in cycle t:
  - FIFO cleared at the edge; any same-cycle pop or push is ignored.
  - discard <= outstanding_after_cycle, i.e. all accepted and not-yet-answered requests, counting any same-cycle response as already dropped.
  - next_pc <= {redirect_pc[31:2],2'b00}. The rsp_pc counter is also reloaded to this value.
  - imem_req_valid=0 in cycle t. Fetch resumes at t+1, with requests issued while discards are still pending.
  - fetch_valid=0 in cycle t+1.
- Back-to-back redirects: the latest one wins; discard accumulates correctly.
- Invariants:
  - occupancy <= DEPTH; outstanding <= MAX_OUTSTANDING.
  - A response with outstanding==0 is ignored.
  - Overflow cannot occur by the credit rule; assertion required.

Decomposition:
- Shared package mips5_pkg: PC/instruction width constant (32), RESET_PC default, NOP encoding 32'h0000_0000, typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module: prefetch_fifo, a synchronous FIFO with parameter DEPTH.
  - Ports: push, pop, clear, full, empty, count, head entry; async active-high reset.
- The top handles credits, discard counter, PC counters and redirect.

Test Plan:
1. Reset release, memory ready=1 with 1-cycle response latency, fetch_ready=1, instrs = addr^32'hA5A5_0000 -> fetch_pc sequence 0,4,8,12 on consecutive cycles from cycle 3, with matching instr.
2. fetch_ready=0 for 10 cycles -> exactly 4 entries buffered, imem_req_valid drops once occupancy+outstanding==4, no overflow; release -> 0,4,8,12 drained in order.
3. Memory latency 3, two requests outstanding (addr 8,12), redirect_pc=32'h100 -> both late responses dropped, next fetch_pc=32'h100, then 32'h104.
4. Redirect in the same cycle as rsp_valid and a head pop -> response dropped, FIFO empty next cycle, discard counts correct, fetch resumes at target.
5. Redirect to 32'hFFFF_FFFC -> fetch_pc FFFF_FFFC then 0000_0000; a misaligned redirect 32'h103 fetches 32'h100.
6. Assert rst with 2 outstanding, then feed 2 stray responses after release -> strays ignored, first fetch_pc=RESET_PC with correct instr.
